vec_state_regfile: RTL and testbench
====================================

// Module: vec_state_regfile
// PURPOSE
//  Parametrised vector register file for the SIMD AES datapath. Holds NUM_STATES
//  independent LANES x LANES byte matrices (AES states / round keys).
//  Provides row or column random access: one write port, two read ports.
//  Adds a burst-load sequencer that streams LANES words into one matrix by row or
//  by column over a valid/ready handshake. Sits between the instruction decoder/
//  memory interface and the SIMD AES lanes.
// PARAMETERS
//  NUM_STATES  4  number of matrices; SW = max(1,$clog2(NUM_STATES))
//  LANES       4  rows = columns per matrix; IW = max(1,$clog2(LANES))
//  BYTE_W      8  element width; WORD_W = LANES*BYTE_W (32 at defaults)
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst_n        in   1       synchronous active-low reset
//  wr_en        in   1       random-access write strobe
//  wr_col       in   1       0 = row write, 1 = column write
//  wr_state     in   SW      target matrix
//  wr_idx       in   IW      row or column index
//  wr_data      in   WORD_W  write word
//  rd_a_state   in   SW      read port A: matrix select (port B: rd_b_state)
//  rd_a_idx     in   IW      read port A: row/column index (port B: rd_b_idx)
//  rd_a_col     in   1       read port A: 0 row, 1 column (port B: rd_b_col)
//  rd_a_data    out  WORD_W  read port A data (port B: rd_b_data)
//  bl_start     in   1       start burst load; sampled only in IDLE
//  bl_state     in   SW      burst target matrix, latched on start
//  bl_col       in   1       burst orientation, latched on start
//  bl_valid     in   1       burst word valid
//  bl_ready     out  1       sequencer accepts word (1 only in LOAD)
//  bl_data      in   WORD_W  burst word
//  bl_busy      out  1       1 in LOAD and DONE
//  bl_done      out  1       1-cycle pulse after last word written
//  wr_conflict  out  1       sticky: random write dropped by burst conflict
// BEHAVIOUR
//  - Layout: word byte k (k=0 at MSBs [WORD_W-1 -: BYTE_W]) = column k of a row.
//  - Row r read/write: the whole row word. Column c read:
//    {m[0][c], m[1][c], ..., m[LANES-1][c]}, row 0 in MSBs. Column write scatters
//    the same mapping. Out-of-range state index: read returns 0, write ignored.
//  - Reads are combinational, both ports independent; any mix of row/col modes.
//  - Reset (rst_n=0 at edge): all matrices 0, FSM IDLE, bl_ready=0, bl_busy=0,
//    bl_done=0, wr_conflict=0. Reset mid-burst aborts it; words already written
//    are also cleared. rst_n has priority over all writes.
//  - FSM IDLE: bl_start=1 -> latch bl_state/bl_col, cnt=0, go LOAD.
//  - FSM LOAD: bl_ready=1; bl_valid&bl_ready writes bl_data to row/col cnt, cnt++;
//    write at cnt=LANES-1 -> DONE. bl_valid=0 stalls indefinitely, no timeout.
//  - FSM DONE: bl_done=1 for exactly this cycle, bl_ready=0, then IDLE.
//    A new burst starts at the earliest in the cycle after DONE.
//  - bl_start outside IDLE ignored. Burst latency: LANES accepted words + 1 cycle.
//  - Same-cycle burst write and random write:
//    - Same matrix: burst wins, random write dropped, wr_conflict set (sticky until reset).
//    - Different matrices: both commit.
//    - Random write while bl_busy to the burst matrix with no burst beat that cycle:
//      dropped, wr_conflict set (the matrix is locked during a burst).
// CONFIGURATION
//  - Macro VEC_RF_BYPASS_EN.
//  - Defined: read ports forward same-cycle committed writes (random and burst)
//    byte-wise. Each read byte reflects the value it will hold after the edge;
//    dropped writes are not forwarded.
//  - Undefined: reads show stored contents only; writes visible the cycle after.
// TESTING
//  - Reset, then read all rows/cols of every state, both ports -> all 0;
//    bl_ready=0, bl_busy=0, wr_conflict=0.
//  - Row write s0 r0..3 = 00112233, 44556677, 8899AABB, CCDDEEFF; column read c1
//    -> 115599DD; row read r2 -> 8899AABB.
//  - Burst s2 col mode, words 01020304, 05060708, 090A0B0C, 0D0E0F10, one stall
//    cycle after word 1 -> row 0 reads 0105090D; bl_done exactly once, 6 cycles
//    after start.
//  - During a burst to s2, random row write to s2 -> dropped, wr_conflict=1.
//    Same-cycle write to s1 -> committed.
//  - Assert rst_n=0 after 2 burst words -> IDLE, s2 all 0, bl_busy=0 next cycle.
//  - Bypass: write row s3 r1=DEADBEEF while port A reads s3 r1 -> DEADBEEF with
//    VEC_RF_BYPASS_EN, 00000000 without.

Source files
------------

// File: rtl/vec_state_regfile.sv
// Vector register file: NUM_STATES LANES x LANES byte matrices, row/col access.
// Burst-load sequencer; optional read bypass via macro VEC_RF_BYPASS_EN.
module vec_state_regfile #(
   parameter int NUM_STATES = 4,
   parameter int LANES      = 4,
   parameter int BYTE_W     = 8,
   localparam int SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int WORD_W = LANES * BYTE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic              wr_col,
   input  logic [SW-1:0]     wr_state,
   input  logic [IW-1:0]     wr_idx,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [SW-1:0]     rd_a_state,
   input  logic [IW-1:0]     rd_a_idx,
   input  logic              rd_a_col,
   output logic [WORD_W-1:0] rd_a_data,
   input  logic [SW-1:0]     rd_b_state,
   input  logic [IW-1:0]     rd_b_idx,
   input  logic              rd_b_col,
   output logic [WORD_W-1:0] rd_b_data,
   input  logic              bl_start,
   input  logic [SW-1:0]     bl_state,
   input  logic              bl_col,
   input  logic              bl_valid,
   output logic              bl_ready,
   input  logic [WORD_W-1:0] bl_data,
   output logic              bl_busy,
   output logic              bl_done,
   output logic              wr_conflict
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } bl_fsm_t;

   bl_fsm_t         state_q, state_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   bl_st_q, bl_st_d;
   logic            bl_col_q, bl_col_d;
   logic            conflict_q, conflict_d;

   logic [BYTE_W-1:0] mem_q [NUM_STATES][LANES][LANES];
   logic [BYTE_W-1:0] mem_d [NUM_STATES][LANES][LANES];
   logic [BYTE_W-1:0] mem_v [NUM_STATES][LANES][LANES];

   logic beat;
   logic lock;
   logic bl_rng;
   logic wr_rng;

   assign bl_ready    = (state_q == LOAD);
   assign bl_busy     = (state_q == LOAD) || (state_q == DONE);
   assign bl_done     = (state_q == DONE);
   assign wr_conflict = conflict_q;

   assign beat   = bl_ready && bl_valid;
   assign lock   = bl_busy && (wr_state == bl_st_q);
   assign bl_rng = int'(bl_st_q) < NUM_STATES;
   assign wr_rng = (int'(wr_state) < NUM_STATES)
                && (int'(wr_idx) < LANES);

   // Burst sequencer next state: latch target on start, count accepted beats.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bl_st_d  = bl_st_q;
      bl_col_d = bl_col_q;
      unique case (state_q)
         IDLE: begin
            if (bl_start) begin
               bl_st_d  = bl_state;
               bl_col_d = bl_col;
               cnt_d    = '0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            if (beat) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == IW'(LANES - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next matrix contents: burst beat first, random write only if unlocked.
   always_comb begin
      mem_d      = mem_q;
      conflict_d = conflict_q;
      if (beat && bl_rng) begin
         for (int k = 0; k < LANES; k++) begin
            if (bl_col_q) begin
               mem_d[bl_st_q][k][cnt_q] =
                  bl_data[WORD_W-1-k*BYTE_W -: BYTE_W];
            end else begin
               mem_d[bl_st_q][cnt_q][k] =
                  bl_data[WORD_W-1-k*BYTE_W -: BYTE_W];
            end
         end
      end
      if (wr_en) begin
         if (lock) begin
            conflict_d = 1'b1;
         end else if (wr_rng) begin
            for (int k = 0; k < LANES; k++) begin
               if (wr_col) begin
                  mem_d[wr_state][k][wr_idx] =
                     wr_data[WORD_W-1-k*BYTE_W -: BYTE_W];
               end else begin
                  mem_d[wr_state][wr_idx][k] =
                     wr_data[WORD_W-1-k*BYTE_W -: BYTE_W];
               end
            end
         end
      end
   end

   // Read source: post-edge contents when forwarding, else stored contents.
   always_comb begin
`ifdef VEC_RF_BYPASS_EN
      mem_v = mem_d;
`else
      mem_v = mem_q;
`endif
   end

   // Combinational read ports, row or column gather per port.
   always_comb begin
      rd_a_data = '0;
      rd_b_data = '0;
      if ((int'(rd_a_state) < NUM_STATES)
          && (int'(rd_a_idx) < LANES)) begin
         for (int k = 0; k < LANES; k++) begin
            rd_a_data[WORD_W-1-k*BYTE_W -: BYTE_W] = rd_a_col ?
               mem_v[rd_a_state][k][rd_a_idx] :
               mem_v[rd_a_state][rd_a_idx][k];
         end
      end
      if ((int'(rd_b_state) < NUM_STATES)
          && (int'(rd_b_idx) < LANES)) begin
         for (int k = 0; k < LANES; k++) begin
            rd_b_data[WORD_W-1-k*BYTE_W -: BYTE_W] = rd_b_col ?
               mem_v[rd_b_state][k][rd_b_idx] :
               mem_v[rd_b_state][rd_b_idx][k];
         end
      end
   end

   // State registers with synchronous reset clearing matrices and FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_STATES; s++) begin
            for (int r = 0; r < LANES; r++) begin
               for (int c = 0; c < LANES; c++) begin
                  mem_q[s][r][c] <= '0;
               end
            end
         end
         state_q    <= IDLE;
         cnt_q      <= '0;
         bl_st_q    <= '0;
         bl_col_q   <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bl_st_q    <= bl_st_d;
         bl_col_q   <= bl_col_d;
         conflict_q <= conflict_d;
      end
   end

endmodule

// File: tb/tb_vec_state_regfile.sv
// Randomized bench for vec_state_regfile against a matrix-level model.
// Also covers directed row/col, burst, conflict, reset and bypass cases.
module tb_vec_state_regfile;

   logic        clk;
   logic        rst_n;
   logic        wr_en, wr_col;
   logic [1:0]  wr_state, wr_idx;
   logic [31:0] wr_data;
   logic [1:0]  rd_a_state, rd_a_idx;
   logic        rd_a_col;
   logic [31:0] rd_a_data;
   logic [1:0]  rd_b_state, rd_b_idx;
   logic        rd_b_col;
   logic [31:0] rd_b_data;
   logic        bl_start;
   logic [1:0]  bl_state;
   logic        bl_col, bl_valid, bl_ready;
   logic [31:0] bl_data;
   logic        bl_busy, bl_done, wr_conflict;

   vec_state_regfile dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_col(wr_col),
      .wr_state(wr_state), .wr_idx(wr_idx),
      .wr_data(wr_data),
      .rd_a_state(rd_a_state), .rd_a_idx(rd_a_idx),
      .rd_a_col(rd_a_col), .rd_a_data(rd_a_data),
      .rd_b_state(rd_b_state), .rd_b_idx(rd_b_idx),
      .rd_b_col(rd_b_col), .rd_b_data(rd_b_data),
      .bl_start(bl_start), .bl_state(bl_state),
      .bl_col(bl_col), .bl_valid(bl_valid),
      .bl_ready(bl_ready), .bl_data(bl_data),
      .bl_busy(bl_busy), .bl_done(bl_done),
      .wr_conflict(wr_conflict)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int busy_seen, done_seen;

   logic [7:0] ref_m [4][4][4];
   logic [7:0] nm [4][4][4];
   bit        b_on, bcol, conf, conf_n, beat;
   int        b_n;
   logic [1:0] bs;

   logic [31:0] bw [4];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [1:0] s,
                                            input logic [1:0] i,
                                            input logic c);
      logic [31:0] r = 0;
      for (int k = 0; k < 4; k++) begin
`ifdef VEC_RF_BYPASS_EN
         r = (r << 8) | 32'(c ? nm[s][k][i] : nm[s][i][k]);
`else
         r = (r << 8) | 32'(c ? ref_m[s][k][i] : ref_m[s][i][k]);
`endif
      end
      return r;
   endfunction

   task automatic zero_model();
      for (int s = 0; s < 4; s++)
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               ref_m[s][r][c] = 8'h00;
      b_on = 0; b_n = 0; conf = 0;
   endtask

   // Compute post-edge model and compare all observable outputs.
   task automatic eval();
      logic [7:0] by;
      #1;
      nm = ref_m;
      conf_n = conf;
      beat = b_on && (b_n < 4) && bl_valid;
      if (beat)
         for (int k = 0; k < 4; k++) begin
            by = 8'(bl_data >> (8 * (3 - k)));
            if (bcol) nm[bs][k][b_n] = by;
            else nm[bs][b_n][k] = by;
         end
      if (wr_en) begin
         if (b_on && wr_state == bs) conf_n = 1;
         else
            for (int k = 0; k < 4; k++) begin
               by = 8'(wr_data >> (8 * (3 - k)));
               if (wr_col) nm[wr_state][k][wr_idx] = by;
               else nm[wr_state][wr_idx][k] = by;
            end
      end
      chk("bl_ready", 32'(bl_ready), 32'(b_on && b_n < 4));
      chk("bl_busy", 32'(bl_busy), 32'(b_on));
      chk("bl_done", 32'(bl_done), 32'(b_on && b_n == 4));
      chk("wr_conflict", 32'(wr_conflict), 32'(conf));
      if (rst_n) begin
         chk("rd_a", rd_a_data,
             model_rd(rd_a_state, rd_a_idx, rd_a_col));
         chk("rd_b", rd_b_data,
             model_rd(rd_b_state, rd_b_idx, rd_b_col));
      end
   endtask

   // Commit model step and advance one clock.
   task automatic adv();
      if (bl_busy) busy_seen++;
      if (bl_done) done_seen++;
      if (!rst_n) zero_model();
      else begin
         ref_m = nm;
         conf = conf_n;
         if (!b_on) begin
            if (bl_start) begin
               b_on = 1; b_n = 0;
               bs = bl_state; bcol = bl_col;
            end
         end else if (b_n == 4) b_on = 0;
         else if (beat) b_n++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wrow(input logic [1:0] s, input logic [1:0] r,
                       input logic [31:0] d);
      wr_en = 1; wr_col = 0;
      wr_state = s; wr_idx = r; wr_data = d;
      eval(); adv();
      wr_en = 0;
   endtask

   task automatic set_rd(input logic [1:0] as, input logic [1:0] ai,
                         input logic ac, input logic [1:0] bsl,
                         input logic [1:0] bi, input logic bc);
      rd_a_state = as; rd_a_idx = ai; rd_a_col = ac;
      rd_b_state = bsl; rd_b_idx = bi; rd_b_col = bc;
   endtask

   initial begin
      clk = 0; rst_n = 0;
      wr_en = 0; wr_col = 0; wr_state = 0; wr_idx = 0;
      wr_data = 0; bl_start = 0; bl_state = 0;
      bl_col = 0; bl_valid = 0; bl_data = 0;
      set_rd(0, 0, 0, 0, 0, 0);
      busy_seen = 0; done_seen = 0;
      repeat (2) @(posedge clk);
      #1;
      zero_model();
      eval(); adv();
      rst_n = 1;

      for (int s = 0; s < 4; s++)
         for (int i = 0; i < 4; i++)
            for (int c = 0; c < 2; c++) begin
               set_rd(2'(s), 2'(i), c[0],
                      2'(3 - s), 2'(3 - i), ~c[0]);
               eval();
               chk("rst_rd_a", rd_a_data, 32'h0);
               chk("rst_rd_b", rd_b_data, 32'h0);
            end
      adv();

      wrow(0, 0, 32'h00112233);
      wrow(0, 1, 32'h44556677);
      wrow(0, 2, 32'h8899AABB);
      wrow(0, 3, 32'hCCDDEEFF);
      set_rd(0, 1, 1, 0, 2, 0);
      eval();
      chk("col_c1", rd_a_data, 32'h115599DD);
      chk("row_r2", rd_b_data, 32'h8899AABB);
      adv();

      bw[0] = 32'h01020304; bw[1] = 32'h05060708;
      bw[2] = 32'h090A0B0C; bw[3] = 32'h0D0E0F10;
      busy_seen = 0; done_seen = 0;
      bl_start = 1; bl_state = 2; bl_col = 1;
      eval(); adv();
      bl_start = 0;
      for (int j = 0, w = 0; j < 5; j++) begin
         if (j == 2) bl_valid = 0;
         else begin
            bl_valid = 1; bl_data = bw[w]; w++;
         end
         eval(); adv();
      end
      bl_valid = 0;
      repeat (2) begin eval(); adv(); end
      chk("done_pulses", 32'(done_seen), 32'd1);
      chk("busy_cycles", 32'(busy_seen), 32'd6);
      set_rd(2, 0, 0, 2, 3, 1);
      eval();
      chk("burst_row0", rd_a_data, 32'h0105090D);
      chk("burst_col3", rd_b_data, 32'h0D0E0F10);
      adv();

      bw[0] = 32'hA0A1A2A3; bw[1] = 32'hB0B1B2B3;
      bw[2] = 32'hC0C1C2C3; bw[3] = 32'hD0D1D2D3;
      bl_start = 1; bl_state = 2; bl_col = 0;
      eval(); adv();
      bl_start = 0;
      bl_valid = 1; bl_data = bw[0];
      wr_en = 1; wr_col = 0; wr_state = 2; wr_idx = 3;
      wr_data = 32'hCAFEF00D;
      eval(); adv();
      bl_data = bw[1];
      wr_state = 1; wr_data = 32'h12345678;
      eval(); adv();
      wr_en = 0;
      chk("conflict_set", 32'(wr_conflict), 32'd1);
      for (int j = 2; j < 4; j++) begin
         bl_data = bw[j];
         eval(); adv();
      end
      bl_valid = 0;
      repeat (2) begin eval(); adv(); end
      set_rd(1, 3, 0, 2, 3, 0);
      eval();
      chk("s1_commit", rd_a_data, 32'h12345678);
      chk("s2_r3_burst", rd_b_data, 32'hD0D1D2D3);
      adv();

      bl_start = 1; bl_state = 2; bl_col = 0;
      eval(); adv();
      bl_start = 0; bl_valid = 1;
      for (int j = 0; j < 2; j++) begin
         bl_data = bw[j] ^ 32'hFFFF0000;
         eval(); adv();
      end
      bl_valid = 0; rst_n = 0;
      eval(); adv();
      rst_n = 1;
      eval();
      chk("busy_after_rst", 32'(bl_busy), 32'd0);
      chk("conf_after_rst", 32'(wr_conflict), 32'd0);
      for (int i = 0; i < 4; i++) begin
         set_rd(2, 2'(i), 0, 2, 2'(i), 1);
         eval();
         chk("rst_s2_row", rd_a_data, 32'h0);
         chk("rst_s2_col", rd_b_data, 32'h0);
      end
      adv();

      wr_en = 1; wr_col = 0; wr_state = 3; wr_idx = 1;
      wr_data = 32'hDEADBEEF;
      set_rd(3, 1, 0, 3, 1, 1);
      eval();
`ifdef VEC_RF_BYPASS_EN
      chk("bypass", rd_a_data, 32'hDEADBEEF);
`else
      chk("bypass", rd_a_data, 32'h0);
`endif
      adv();
      wr_en = 0;
      eval();
      chk("after_wr", rd_a_data, 32'hDEADBEEF);
      adv();

      for (int n = 0; n < 3000; n++) begin
         rst_n    = ($urandom_range(0, 199) != 0);
         wr_en    = $urandom_range(0, 1) == 1;
         wr_col   = $urandom_range(0, 1) == 1;
         wr_state = 2'($urandom_range(0, 3));
         wr_idx   = 2'($urandom_range(0, 3));
         wr_data  = $urandom;
         bl_start = ($urandom_range(0, 9) == 0);
         bl_state = $urandom_range(0, 1) == 1 ?
                    wr_state : 2'($urandom_range(0, 3));
         bl_col   = $urandom_range(0, 1) == 1;
         bl_valid = ($urandom_range(0, 9) < 7);
         bl_data  = $urandom;
         set_rd(2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1);
         eval(); adv();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
